mod_updown_counter: RTL and testbench

Parametrised up/down modulo counter with synchronous load, direction control, and a selectable wrap or saturate mode. It also provides a terminal-count pulse, a sticky overflow flag, and an optional prescaler. It is the general-purpose successor to the fixed 4-bit up counter and is used wherever a timer, event counter or address generator needs a configurable width, range and direction.

---
 rtl/mod_updown_counter.sv | 145 ++++++++++++++
 tb/tb_mod_updown_counter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mod_updown_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mod_updown_counter                                              |
// | Purpose  : Parametrised up/down modulo counter with synchronous load,      |
// |            direction control, wrap or saturate bound behaviour, a          |
// |            one-cycle terminal-count pulse, a sticky overflow flag and an    |
// |            optional prescaler (enabled by defining COUNTER_PRESCALE_EN).   |
// | Ports    : clk       - clock, all state changes on rising edge             |
// |            rst_n     - asynchronous active-low reset                       |
// |            en        - count enable; counter and prescaler hold when low   |
// |            up_dn     - direction, 1 = up, 0 = down                         |
// |            saturate  - 1 = stop at bound, 0 = wrap modulo                  |
// |            load      - synchronous load strobe (highest priority)          |
// |            load_val  - value to load, clamped to MODULO-1                  |
// |            clr_ovf   - clears the sticky overflow flag                     |
// |            count     - current count (registered)                          |
// |            tc        - terminal-count pulse after a bound step             |
// |            ovf       - sticky wrap flag                                    |
// | Macro    : COUNTER_PRESCALE_EN - adds a PRESCALE-cycle step prescaler      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mod_updown_counter #(
  parameter int WIDTH    = 8,
  parameter int MODULO   = 256,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             saturate,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  // Constants are kept WIDTH+1 bits wide so MODULO = 2^WIDTH is representable
  // and the load clamp comparison cannot overflow.
  localparam logic [WIDTH:0] MOD_EXT  = (WIDTH+1)'(MODULO);
  localparam logic [WIDTH:0] LAST_EXT = (WIDTH+1)'(MODULO - 1);
  localparam logic [WIDTH:0] ONE_EXT  = (WIDTH+1)'(1);

  // Elaboration-time parameter legality checks.
  if (WIDTH < 2) begin : g_bad_width
    $error("mod_updown_counter: WIDTH must be >= 2");
  end
  if ((MODULO < 2) || (MODULO > (1 << WIDTH))) begin : g_bad_modulo
    $error("mod_updown_counter: MODULO must be in 2..2^WIDTH");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("mod_updown_counter: PRESCALE must be >= 1");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             step;
  logic             at_bound;
  logic             wrap;
  logic [WIDTH:0]   count_ext;
  logic [WIDTH:0]   load_ext;
  logic [WIDTH:0]   next_ext;

`ifdef COUNTER_PRESCALE_EN
  // Prescaler: counts enabled cycles 0..PRESCALE-1; a step is taken on the
  // enabled cycle where it sits at PRESCALE-1. A load restarts the phase.
  localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);

  logic [PS_W-1:0] presc_q, presc_d;
  logic            presc_done;

  always_comb begin
    presc_done = (presc_q == PS_LAST);
    presc_d    = presc_q;
    if (load) begin
      presc_d = '0;
    end else if (en) begin
      presc_d = presc_done ? '0 : (presc_q + PS_ONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  assign step = en & ~load & presc_done;
`else
  assign step = en & ~load;
`endif

  always_comb begin
    count_ext = {1'b0, count_q};
    load_ext  = {1'b0, load_val};
    at_bound  = up_dn ? (count_ext == LAST_EXT) : (count_ext == '0);
    wrap      = step & at_bound & ~saturate;

    next_ext = count_ext;
    if (load) begin
      next_ext = (load_ext >= MOD_EXT) ? LAST_EXT : load_ext;
    end else if (step) begin
      if (!at_bound) begin
        next_ext = up_dn ? (count_ext + ONE_EXT) : (count_ext - ONE_EXT);
      end else if (!saturate) begin
        next_ext = up_dn ? '0 : LAST_EXT;
      end
    end

    // The bound check keeps next_ext inside 0..MODULO-1, so the extra MSB is
    // never set; it is folded into a clamp so an out-of-range value can
    // never reach the register.
    count_d = next_ext[WIDTH] ? LAST_EXT[WIDTH-1:0] : next_ext[WIDTH-1:0];

    // Loads and holds leave step low, so tc is only raised by a bound step.
    tc_d  = step & at_bound;
    // A wrap on the same edge as clr_ovf leaves the flag set.
    ovf_d = wrap | (ovf_q & ~clr_ovf);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_mod_updown_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mod_updown_counter                                           |
// | Purpose  : Self-checking bench for mod_updown_counter (WIDTH 8, MODULO 10) |
// |            using directed steps followed by random stimulus, compared      |
// |            against a behavioural reference model.                          |
// | Macro    : COUNTER_PRESCALE_EN - also exercises the prescaler              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_mod_updown_counter;

  localparam int WIDTH    = 8;
  localparam int MODULO   = 10;
  localparam int PRESCALE = 4;
`ifdef COUNTER_PRESCALE_EN
  localparam bit PS_ON    = 1'b1;
  localparam int STEP_CYC = PRESCALE;
`else
  localparam bit PS_ON    = 1'b0;
  localparam int STEP_CYC = 1;
`endif

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             up_dn;
  logic             saturate;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             clr_ovf;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             ovf;

  // Reference model state
  int m_cnt;
  int m_phase;
  bit m_tc;
  bit m_ovf;

  int n_checks;
  int n_fail;

  mod_updown_counter #(
    .WIDTH    (WIDTH),
    .MODULO   (MODULO),
    .PRESCALE (PRESCALE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up_dn    (up_dn),
    .saturate (saturate),
    .load     (load),
    .load_val (load_val),
    .clr_ovf  (clr_ovf),
    .count    (count),
    .tc       (tc),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(m_cnt));
    chk({tag, ".tc"},    32'(tc),    32'(m_tc));
    chk({tag, ".ovf"},   32'(ovf),   32'(m_ovf));
  endtask

  task automatic model_reset();
    m_cnt   = 0;
    m_phase = 0;
    m_tc    = 1'b0;
    m_ovf   = 1'b0;
  endtask

  // Behavioural view of one rising edge: load > step > hold.
  task automatic model_edge(input bit e, input bit u, input bit s, input bit l,
                            input int lv, input bit c);
    bit stp   = 1'b0;
    bit bound = 1'b0;
    bit wrp   = 1'b0;
    if (l) begin
      m_cnt   = (lv >= MODULO) ? MODULO - 1 : lv;
      m_phase = 0;
    end else if (e) begin
      m_phase = m_phase + 1;
      if (!PS_ON || m_phase == PRESCALE) begin
        m_phase = 0;
        stp     = 1'b1;
      end
    end
    if (stp) begin
      bound = u ? (m_cnt == MODULO - 1) : (m_cnt == 0);
      if (!bound) begin
        m_cnt = u ? m_cnt + 1 : m_cnt - 1;
      end else if (!s) begin
        m_cnt = u ? 0 : MODULO - 1;
        wrp   = 1'b1;
      end
    end
    m_tc = bound;
    if (wrp)    m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
  endtask

  // Drive one cycle of inputs, advance one edge, then check 1 time unit later.
  task automatic cyc(input string tag, input bit e, input bit u, input bit s,
                     input bit l, input int lv, input bit c);
    en       = e;
    up_dn    = u;
    saturate = s;
    load     = l;
    load_val = WIDTH'(lv);
    clr_ovf  = c;
    @(posedge clk);
    model_edge(e, u, s, l, lv, c);
    #1;
    check_all(tag);
  endtask

  initial begin
    bit en_pat [9] = '{1, 1, 0, 1, 1, 1, 1, 1, 1};
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    up_dn    = 1'b1;
    saturate = 1'b0;
    load     = 1'b0;
    load_val = '0;
    clr_ovf  = 1'b0;
    model_reset();

    // Reset state, then release away from the rising edge.
    #12;
    check_all("reset");
    rst_n = 1'b1;

    // Up count through the wrap: 1..9, 0, 1, 2 (per step).
    repeat (12 * STEP_CYC) cyc("up_wrap", 1, 1, 0, 0, 0, 0);
    chk("up_wrap.final_count", 32'(count), 32'd2);
    chk("up_wrap.final_ovf",   32'(ovf),   32'd1);

    // Asynchronous reset mid-count at 7, asserted off-edge.
    cyc("pre_rst_load", 0, 1, 0, 1, 6, 0);
    repeat (STEP_CYC) cyc("pre_rst_step", 1, 1, 0, 0, 0, 0);
    chk("pre_rst.count", 32'(count), 32'd7);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #2;
    rst_n = 1'b1;

    // Down saturate from 2: 1, 0, 0, 0 with tc on the two held steps.
    cyc("dsat_load", 0, 0, 1, 1, 2, 0);
    repeat (4 * STEP_CYC) cyc("down_sat", 1, 0, 1, 0, 0, 0);

    // Load priority over enable, clamp 15 -> 9, then wrap to 0.
    cyc("load_clamp", 1, 1, 0, 1, 15, 0);
    chk("load_clamp.value", 32'(count), 32'd9);
    repeat (STEP_CYC) cyc("clamp_step", 1, 1, 0, 0, 0, 0);

    // ovf: clear alone, then wrap and clear together (set wins), then clear.
    cyc("clr_alone", 0, 1, 0, 0, 0, 1);
    cyc("coll_load", 0, 1, 0, 1, 9, 0);
    repeat (STEP_CYC) cyc("coll_wrap", 1, 1, 0, 0, 0, 1);
    chk("coll_wrap.ovf_kept", 32'(ovf), 32'd1);
    cyc("clr_after", 0, 1, 0, 0, 0, 1);

`ifdef COUNTER_PRESCALE_EN
    // Eight enabled cycles with a one-cycle gap: steps on 4th and 8th.
    cyc("ps_load", 0, 1, 0, 1, 0, 0);
    foreach (en_pat[i]) cyc("ps_gap", en_pat[i], 1, 0, 0, 0, 0);
    chk("ps_gap.two_steps", 32'(count), 32'd2);
    // A load mid-phase restarts the 4-cycle phase.
    cyc("ps_mid", 1, 1, 0, 0, 0, 0);
    cyc("ps_mid", 1, 1, 0, 0, 0, 0);
    cyc("ps_reload", 1, 1, 0, 1, 3, 0);
    repeat (3) cyc("ps_phase", 1, 1, 0, 0, 0, 0);
    chk("ps_phase.no_step", 32'(count), 32'd3);
    cyc("ps_phase4", 1, 1, 0, 0, 0, 0);
    chk("ps_phase4.step", 32'(count), 32'd4);
`else
    foreach (en_pat[i]) cyc("en_gap", en_pat[i], 1, 0, 0, 0, 0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cyc("random",
          ($urandom_range(0, 3) != 0),
          1'($urandom),
          1'($urandom),
          ($urandom_range(0, 9) == 0),
          int'($urandom_range(0, 255)),
          ($urandom_range(0, 9) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
